store_rmw_unit: RTL and testbench
=================================

# store_rmw_unit

Sequential store-merge unit between the load/store stage and a word-organised data memory. Accepts byte/half/word (and double, when DW=64) store requests at arbitrary byte addresses, reads the old memory word, merges the store bytes into the addressed lanes and writes the word back. The block is the sole writer of its memory port. It replaces the purely combinational store merge with a handshaked read-modify-write sequencer and an optional last-word bypass.

## Interface
- DW, 32, data/word width in bits; 32 or 64 only.
- AW, 32, byte address width.
- WB = DW/8 bytes per word; OFS = log2(WB) lane-offset bits (derived, not overridable).

- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  store request valid.
- req_ready_o  out  1  unit can accept a request.
- req_addr_i  in  AW  byte address.
- req_data_i  in  DW  store data, right-aligned (low bytes used).
- req_opcode_i  in  4  0 sb, 1 sh, 2 sw, 3 sd (legal only when DW=64); others illegal.
- flush_i  in  1  invalidate bypass entry (no effect without macro).
- mem_addr_o  out  AW-OFS  word address.
- mem_rd_o  out  1  read strobe; data returned on mem_rdata_i next cycle.
- mem_rdata_i  in  DW  read data.
- mem_wr_o  out  1  write strobe.
- mem_wdata_o  out  DW  merged write data.
- done_o  out  1  one-cycle pulse, store committed.
- err_o  out  1  one-cycle pulse, request rejected.
- busy_o  out  1  state is not IDLE.

## Operation
- States: IDLE, READ, WAIT, WRITE, ERR.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o latch addr, data, opcode; word address = addr[AW-1:OFS], lane offset = addr[OFS-1:0].
- Size S bytes = 1<<opcode. Illegal if opcode>3, opcode==3 with DW=32, or offset not a multiple of S -> ERR.
- Full-word store (S==WB) -> WRITE directly, no read; merged = req_data.
- Partial store -> READ (bypass hit: see Configuration).
- READ: mem_rd_o=1 with mem_addr_o valid -> WAIT.
- WAIT: capture mem_rdata_i as old word -> WRITE.
- Merge: mask = ((1<<8S)-1) << 8·offset; shifted = data << 8·offset; merged = (old & ~mask) | (shifted & mask), truncated to DW.
- WRITE: mem_wr_o=1, mem_wdata_o=merged, done_o=1 -> IDLE.
- ERR: err_o=1, no mem strobe -> IDLE.
- req_valid_i outside IDLE is ignored (ready low); requester holds it.
- flush_i simultaneous with a hit check takes priority: treated as miss.

## Timing
- Accept at cycle T. Partial miss: READ T+1, WAIT T+2, WRITE/done T+3, ready again T+4. Full word or bypass hit: WRITE/done T+1. Error: err_o T+1.
- Throughput: one partial store per 4 cycles; full/hit one per 2 cycles.
- mem_addr_o, mem_wdata_o are registered, hold their last value between operations.
- Reset values: state IDLE, req_ready_o=1 after the reset cycle (0 while rst_i high), mem_rd_o=0, mem_wr_o=0, done_o=0, err_o=0, busy_o=0, mem_addr_o=0, mem_wdata_o=0, bypass valid=0.
- Reset in any state aborts: no mem_wr_o in or after the reset cycle, no done_o/err_o for the aborted request.

## Configuration
- STORE_BYPASS_EN defined: one-entry register holds the word address and data of the last WRITE plus a valid bit. A partial store whose word address matches a valid entry skips READ/WAIT and merges into the held word (IDLE -> WRITE). Entry updates on every WRITE; cleared by rst_i or flush_i.
- Not defined: no entry; every partial store performs READ/WAIT; flush_i ignored.

## Test plan
- DW=32, mem[0x40]=0xAABBCCDD; sb addr 0x101 data 0x11 -> mem_rd_o T+1 addr 0x40, mem_wr_o T+3 wdata 0xAABB11DD, done_o T+3.
- Same word, sh addr 0x102 data 0x12345678 -> wdata 0x5678CCDD at T+3.
- sw addr 0x104 data 0xDEADBEEF -> no mem_rd_o, mem_wr_o T+1 addr 0x41 wdata 0xDEADBEEF.
- sh addr 0x101 -> err_o T+1, no strobes; opcode 3 with DW=32 and opcode 5 -> err_o each; DW=64 sd addr 0x8 -> full write T+1.
- STORE_BYPASS_EN: sb 0x100 data 0x01 then sb 0x103 data 0x02 over 0xAABBCCDD -> second writes 0x02BBCC01 at T+1, no mem_rd_o; repeat with flush_i between -> second performs READ.
- rst_i high during WAIT -> no mem_wr_o, no done_o; req_ready_o=1 the cycle after rst_i falls.

Source files
------------

// File: rtl/store_rmw_if.sv
// -----------------------------------------------------------------------------
// store_rmw_if
// Bundles the request handshake and the data-memory port of store_rmw_unit.
//
// Handshake: a request transfers on a rising clock edge where req_valid_i and
// req_ready_o are both high. The requester holds req_valid_i and its payload
// stable until that edge. The unit may drop req_ready_o at any time.
//
// Signal names keep the unit-side _i/_o direction suffixes.
// Ports (unit side):
//   req_valid_i/req_ready_o/req_addr_i/req_data_i/req_opcode_i  store request
//   flush_i                                                     bypass invalidate
//   mem_addr_o/mem_rd_o/mem_rdata_i/mem_wr_o/mem_wdata_o        memory port
//   done_o/err_o/busy_o                                         status
// Modports: slave = the unit, master = requester + memory side.
// -----------------------------------------------------------------------------
interface store_rmw_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    localparam int OFS = $clog2(DW / 8);

    logic              req_valid_i;
    logic              req_ready_o;
    logic [AW-1:0]     req_addr_i;
    logic [DW-1:0]     req_data_i;
    logic [3:0]        req_opcode_i;
    logic              flush_i;
    logic [AW-OFS-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic [DW-1:0]     mem_rdata_i;
    logic              mem_wr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              done_o;
    logic              err_o;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_opcode_i, flush_i, mem_rdata_i,
        output req_ready_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o, done_o, err_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_opcode_i, flush_i, mem_rdata_i,
        input  req_ready_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o, done_o, err_o, busy_o
    );
endinterface

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
// Read-modify-write store sequencer. Takes byte/half/word(/double) stores at
// any byte address, reads the old memory word, merges the store bytes into the
// addressed lanes and writes the word back. Full-word stores skip the read.
// Misaligned or unsupported stores are rejected with an err_o pulse.
//
// Optional feature macro: STORE_BYPASS_EN
//   Defined: a one-entry buffer keeps the last written word; a partial store to
//   that word merges into it and skips READ/WAIT. flush_i invalidates it.
//   Undefined: every partial store reads memory; flush_i is ignored.
//
// Ports:
//   clk_i        clock (rising edge)
//   rst_i        synchronous active-high reset
//   bus          store_rmw_if.slave (request handshake + memory port + status)
//   state_dbg_o  current FSM state (IDLE=0 READ=1 WAIT=2 WRITE=3 ERR=4)
// -----------------------------------------------------------------------------
module store_rmw_unit #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    store_rmw_if.slave        bus,
    output logic [2:0]        state_dbg_o
);
    localparam int WB  = DW / 8;
    localparam int OFS = $clog2(WB);
    localparam int WAW = AW - OFS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [WAW-1:0] addr_q, addr_d;     // drives mem_addr_o
    logic [DW-1:0]  wdata_q, wdata_d;   // drives mem_wdata_o
    logic [DW-1:0]  data_q, data_d;     // latched store data
    logic [1:0]     size_q, size_d;     // log2 of store size in bytes
    logic [OFS-1:0] ofs_q, ofs_d;       // byte lane offset

    // Place the low (1<<lsz) bytes of st at lane ofs inside old_w.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0]  old_w,
                                            input logic [DW-1:0]  st,
                                            input logic [1:0]     lsz,
                                            input logic [OFS-1:0] ofs);
        logic [DW-1:0] mask;
        logic [DW-1:0] shifted;
        int            nbytes;
        nbytes = 1 << lsz;
        mask   = '0;
        for (int i = 0; i < WB; i++) begin
            if (i >= int'(ofs) && i < int'(ofs) + nbytes) mask[8*i +: 8] = 8'hFF;
        end
        shifted = st << {ofs, 3'b000};
        return (old_w & ~mask) | (shifted & mask);
    endfunction

    // Request decode
    logic [3:0]     req_op;
    logic [OFS-1:0] req_ofs;
    logic [WAW-1:0] req_word;
    logic [3:0]     size_m1;
    logic           req_illegal;
    logic           req_full;
    logic           byp_hit;

    assign req_op   = bus.req_opcode_i;
    assign req_ofs  = bus.req_addr_i[OFS-1:0];
    assign req_word = bus.req_addr_i[AW-1:OFS];
    assign size_m1  = (4'd1 << req_op[1:0]) - 4'd1;
    // Alignment: the offset must have no bits set below the store size.
    assign req_illegal = (req_op > 4'd3) || (req_op == 4'd3 && DW == 32)
                       || ((4'(req_ofs) & size_m1) != 4'd0);
    assign req_full    = ((4'd1 << req_op[1:0]) == 4'(WB));

`ifdef STORE_BYPASS_EN
    logic           byp_valid_q, byp_valid_d;
    logic [WAW-1:0] byp_addr_q, byp_addr_d;
    logic [DW-1:0]  byp_data_q, byp_data_d;

    // A flush in the same cycle as the lookup forces a miss.
    assign byp_hit = byp_valid_q && !bus.flush_i && (byp_addr_q == req_word);

    always_comb begin
        byp_valid_d = byp_valid_q;
        byp_addr_d  = byp_addr_q;
        byp_data_d  = byp_data_q;
        if (state_q == S_WRITE) begin
            byp_valid_d = 1'b1;
            byp_addr_d  = addr_q;
            byp_data_d  = wdata_q;
        end
        if (bus.flush_i) byp_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byp_valid_q <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
        end else begin
            byp_valid_q <= byp_valid_d;
            byp_addr_q  <= byp_addr_d;
            byp_data_q  <= byp_data_d;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = bus.flush_i;
    assign byp_hit      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        size_d  = size_q;
        ofs_d   = ofs_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    if (req_illegal) begin
                        // Rejected requests leave the memory-side registers alone.
                        state_d = S_ERR;
                    end else begin
                        addr_d = req_word;
                        data_d = bus.req_data_i;
                        size_d = req_op[1:0];
                        ofs_d  = req_ofs;
                        if (req_full) begin
                            wdata_d = bus.req_data_i;
                            state_d = S_WRITE;
                        end else if (byp_hit) begin
`ifdef STORE_BYPASS_EN
                            wdata_d = merge(byp_data_q, bus.req_data_i, req_op[1:0], req_ofs);
`endif
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                wdata_d = merge(bus.mem_rdata_i, data_q, size_q, ofs_q);
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            size_q  <= '0;
            ofs_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            size_q  <= size_d;
            ofs_q   <= ofs_d;
        end
    end

    // Strobes are masked by rst_i so an aborted operation never reaches memory.
    assign bus.req_ready_o = (state_q == S_IDLE)  && !rst_i;
    assign bus.mem_rd_o    = (state_q == S_READ)  && !rst_i;
    assign bus.mem_wr_o    = (state_q == S_WRITE) && !rst_i;
    assign bus.done_o      = (state_q == S_WRITE) && !rst_i;
    assign bus.err_o       = (state_q == S_ERR)   && !rst_i;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  store_rmw_if #(.DW(32), .AW(32)) bus ();

  store_rmw_unit #(.DW(32), .AW(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears the cycle after mem_rd_o.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_rd_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[7:0]];
  end

  // Observations of the last run_store, cycle numbers relative to accept (-1 = never)
  int          rd_cyc, wr_cyc, done_cyc, err_cyc, rdy_cyc, rd_cnt, wr_cnt;
  logic [29:0] rd_addr, wr_addr;
  logic [31:0] wr_data;

  task automatic preload(input int word, input logic [31:0] val);
    mem[word] = val;
    @(negedge clk); bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] op, input int rst_at);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout got %b want 1", bus.req_ready_o);
      return;
    end
    bus.req_valid_i = 1'b1; bus.req_addr_i = addr; bus.req_data_i = data; bus.req_opcode_i = op;
    rd_cyc = -1; wr_cyc = -1; done_cyc = -1; err_cyc = -1; rdy_cyc = -1; rd_cnt = 0; wr_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid_i = 1'b0;
      if (rst_at > 0 && k == rst_at) rst = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) rst = 1'b0;
      #1;
      if (bus.mem_rd_o === 1'b1) begin
        rd_cnt++;
        if (rd_cyc < 0) begin rd_cyc = k; rd_addr = bus.mem_addr_o; end
      end
      if (bus.mem_wr_o === 1'b1) begin
        wr_cnt++;
        if (wr_cyc < 0) begin wr_cyc = k; wr_addr = bus.mem_addr_o; wr_data = bus.mem_wdata_o; end
        mem[bus.mem_addr_o[7:0]] = bus.mem_wdata_o;
      end
      if (bus.done_o === 1'b1 && done_cyc < 0) done_cyc = k;
      if (bus.err_o === 1'b1 && err_cyc < 0) err_cyc = k;
      if (bus.req_ready_o === 1'b1 && rdy_cyc < 0) rdy_cyc = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.req_ready_o); end
    checks++; if ({bus.mem_rd_o, bus.mem_wr_o, bus.done_o, bus.err_o, bus.busy_o} !== 5'b0) begin
      errors++; $display("FAIL rst_strobes got %b want 00000", {bus.mem_rd_o, bus.mem_wr_o, bus.done_o, bus.err_o, bus.busy_o});
    end
    checks++; if (bus.mem_addr_o !== 30'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus.mem_wdata_o); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", bus.req_ready_o); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL post_rst_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_partial();
    preload(32'h40, 32'hAABBCCDD);
    run_store(32'h101, 32'h11, 4'd0, 0);
    checks++; if (rd_cyc !== 1) begin errors++; $display("FAIL sb_rd_cyc got %0d want 1", rd_cyc); end
    checks++; if (rd_addr !== 30'h40) begin errors++; $display("FAIL sb_rd_addr got %h want 40", rd_addr); end
    checks++; if (wr_cyc !== 3) begin errors++; $display("FAIL sb_wr_cyc got %0d want 3", wr_cyc); end
    checks++; if (wr_data !== 32'hAABB11DD) begin errors++; $display("FAIL sb_wdata got %h want aabb11dd", wr_data); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL sb_done_cyc got %0d want 3", done_cyc); end
    checks++; if (rdy_cyc !== 4) begin errors++; $display("FAIL sb_ready_cyc got %0d want 4", rdy_cyc); end
    checks++; if (rd_cnt !== 1 || wr_cnt !== 1 || err_cyc !== -1) begin
      errors++; $display("FAIL sb_counts got rd=%0d wr=%0d err=%0d want 1 1 -1", rd_cnt, wr_cnt, err_cyc);
    end
    preload(32'h40, 32'hAABBCCDD);
    run_store(32'h102, 32'h12345678, 4'd1, 0);
    checks++; if (wr_cyc !== 3 || wr_data !== 32'h5678CCDD) begin
      errors++; $display("FAIL sh_merge got cyc=%0d data=%h want 3 5678ccdd", wr_cyc, wr_data);
    end
  endtask

  task automatic test_full_word();
    run_store(32'h104, 32'hDEADBEEF, 4'd2, 0);
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL sw_no_read got %0d want 0", rd_cnt); end
    checks++; if (wr_cyc !== 1 || done_cyc !== 1) begin
      errors++; $display("FAIL sw_wr_cyc got wr=%0d done=%0d want 1 1", wr_cyc, done_cyc);
    end
    checks++; if (wr_addr !== 30'h41 || wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_write got addr=%h data=%h want 41 deadbeef", wr_addr, wr_data);
    end
    checks++; if (rdy_cyc !== 2) begin errors++; $display("FAIL sw_ready_cyc got %0d want 2", rdy_cyc); end
  endtask

  task automatic test_error();
    logic [31:0] addrs [4] = '{32'h101, 32'h100, 32'h100, 32'h102};
    logic [3:0]  ops   [4] = '{4'd1, 4'd3, 4'd5, 4'd2};
    for (int i = 0; i < 4; i++) begin
      run_store(addrs[i], 32'h55AA55AA, ops[i], 0);
      checks++; if (err_cyc !== 1 || rd_cnt !== 0 || wr_cnt !== 0 || done_cyc !== -1) begin
        errors++; $display("FAIL err_case%0d got err=%0d rd=%0d wr=%0d done=%0d want 1 0 0 -1", i, err_cyc, rd_cnt, wr_cnt, done_cyc);
      end
      checks++; if (rdy_cyc !== 2) begin errors++; $display("FAIL err_ready%0d got %0d want 2", i, rdy_cyc); end
    end
    checks++; if (bus.mem_addr_o !== 30'h41 || bus.mem_wdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_hold got addr=%h data=%h want 41 deadbeef", bus.mem_addr_o, bus.mem_wdata_o);
    end
  endtask

  task automatic test_lanes();
    preload(32'h40, 32'h00000000);
    run_store(32'h103, 32'hFFFFFF77, 4'd0, 0);
    checks++; if (wr_data !== 32'h77000000) begin errors++; $display("FAIL sb_lane3 got %h want 77000000", wr_data); end
    preload(32'h40, 32'h11223344);
    run_store(32'h100, 32'hFFFFABCD, 4'd1, 0);
    checks++; if (wr_data !== 32'h1122ABCD) begin errors++; $display("FAIL sh_lane0 got %h want 1122abcd", wr_data); end
    run_store(32'h100, 32'h000000EE, 4'd0, 0);
    checks++; if (wr_data !== 32'h1122ABEE) begin errors++; $display("FAIL sb_lane0 got %h want 1122abee", wr_data); end
  endtask

  task automatic test_back_to_back();
    int          wr_n = 0;
    int          wr_k [2];
    logic [29:0] wa [2];
    logic [31:0] wd [2];
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h104; bus.req_data_i = 32'h01020304; bus.req_opcode_i = 4'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin bus.req_addr_i = 32'h108; bus.req_data_i = 32'h0A0B0C0D; end
      if (k == 3) bus.req_valid_i = 1'b0;
      #1;
      if (bus.mem_wr_o === 1'b1) begin
        if (wr_n < 2) begin wr_k[wr_n] = k; wa[wr_n] = bus.mem_addr_o; wd[wr_n] = bus.mem_wdata_o; end
        wr_n++;
      end
    end
    checks++; if (wr_n !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", wr_n); end
    if (wr_n >= 2) begin
      checks++; if (wr_k[0] !== 1 || wr_k[1] !== 3) begin
        errors++; $display("FAIL b2b_cycles got %0d %0d want 1 3", wr_k[0], wr_k[1]);
      end
      checks++; if (wd[0] !== 32'h01020304 || wa[1] !== 30'h42 || wd[1] !== 32'h0A0B0C0D) begin
        errors++; $display("FAIL b2b_data got %h %h %h want 01020304 42 0a0b0c0d", wd[0], wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    preload(32'h40, 32'hAABBCCDD);
    run_store(32'h101, 32'h11, 4'd0, 2);
    checks++; if (wr_cnt !== 0 || done_cyc !== -1) begin
      errors++; $display("FAIL abort_wait got wr=%0d done=%0d want 0 -1", wr_cnt, done_cyc);
    end
    checks++; if (rdy_cyc !== 3) begin errors++; $display("FAIL abort_wait_ready got %0d want 3", rdy_cyc); end
    run_store(32'h101, 32'h11, 4'd0, 3);
    checks++; if (wr_cnt !== 0 || done_cyc !== -1) begin
      errors++; $display("FAIL abort_write got wr=%0d done=%0d want 0 -1", wr_cnt, done_cyc);
    end
    checks++; if (rdy_cyc !== 4) begin errors++; $display("FAIL abort_write_ready got %0d want 4", rdy_cyc); end
  endtask

`ifdef STORE_BYPASS_EN
  task automatic test_bypass();
    preload(32'h40, 32'hAABBCCDD);
    run_store(32'h100, 32'h01, 4'd0, 0);
    checks++; if (wr_data !== 32'hAABBCC01) begin errors++; $display("FAIL byp_first got %h want aabbcc01", wr_data); end
    run_store(32'h103, 32'h02, 4'd0, 0);
    checks++; if (rd_cnt !== 0 || wr_cyc !== 1 || wr_data !== 32'h02BBCC01) begin
      errors++; $display("FAIL byp_hit got rd=%0d cyc=%0d data=%h want 0 1 02bbcc01", rd_cnt, wr_cyc, wr_data);
    end
    @(negedge clk); bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
    run_store(32'h103, 32'h03, 4'd0, 0);
    checks++; if (rd_cyc !== 1 || wr_cyc !== 3 || wr_data !== 32'h03BBCC01) begin
      errors++; $display("FAIL byp_flush got rd=%0d cyc=%0d data=%h want 1 3 03bbcc01", rd_cyc, wr_cyc, wr_data);
    end
  endtask
`endif

  initial begin
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_data_i = '0; bus.req_opcode_i = '0; bus.flush_i = 1'b0;
    test_reset();
    test_partial();
    test_full_word();
    test_error();
    test_lanes();
    test_back_to_back();
    test_reset_abort();
`ifdef STORE_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
